// File: rtl/ram_arbiter.sv
// ram_arbiter: shares one single-port RAM between the CPU fetch port and a
// host loader/debug port. Every access goes IDLE -> ACCESS -> RESP. Ties are
// broken round-robin or in the host's favour. In host-priority mode a
// starvation counter forces a CPU grant after STARVE_MAX host wins.
module ram_arbiter #(
    parameter int AW         = 16,
    parameter int DW         = 16,
    parameter int STARVE_MAX = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          cpu_req,
    input  logic [AW-1:0] cpu_addr,
    output logic [DW-1:0] cpu_rdata,
    output logic          cpu_ack,
    input  logic          host_req,
    input  logic          host_we,
    input  logic [AW-1:0] host_addr,
    input  logic [DW-1:0] host_wdata,
    input  logic          host_prio,
    output logic [DW-1:0] host_rdata,
    output logic          host_ack,
    output logic          gnt_host,
    output logic          ram_en,
    output logic          ram_we,
    output logic [AW-1:0] ram_addr,
    output logic [DW-1:0] ram_wdata,
    input  logic [DW-1:0] ram_rdata
);

    localparam int SW = $clog2(STARVE_MAX + 1);
    localparam logic [SW-1:0] STARVE_LIM = SW'(STARVE_MAX);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] ACCESS = 2'd1;
    localparam logic [1:0] RESP   = 2'd2;

    logic [1:0]    state_q, state_d;
    logic          ram_en_q, ram_en_d;
    logic          ram_we_q, ram_we_d;
    logic [AW-1:0] ram_addr_q, ram_addr_d;
    logic [DW-1:0] ram_wdata_q, ram_wdata_d;
    logic          win_host_q, win_host_d;
    logic          last_host_q, last_host_d;
    logic [SW-1:0] starve_q, starve_d;
    logic          grant_host;

    // Pick the winner from the requests present this cycle (meaningful in IDLE only)
    always_comb begin
        grant_host = 1'b0;
        if (host_req && !cpu_req) begin
            grant_host = 1'b1;
        end else if (host_req && cpu_req) begin
            if (host_prio) begin
                grant_host = (starve_q != STARVE_LIM);
            end else begin
                grant_host = !last_host_q;
            end
        end
    end

    // Next-state logic: latch the winner's access in IDLE, pulse ram_en in ACCESS, ack in RESP
    always_comb begin
        state_d     = state_q;
        ram_en_d    = ram_en_q;
        ram_we_d    = ram_we_q;
        ram_addr_d  = ram_addr_q;
        ram_wdata_d = ram_wdata_q;
        win_host_d  = win_host_q;
        last_host_d = last_host_q;
        starve_d    = starve_q;
        case (state_q)
            IDLE: begin
                if (!cpu_req) begin
                    starve_d = '0;
                end
                if (cpu_req || host_req) begin
                    state_d     = ACCESS;
                    ram_en_d    = 1'b1;
                    win_host_d  = grant_host;
                    last_host_d = grant_host;
                    if (grant_host) begin
                        ram_we_d    = host_we;
                        ram_addr_d  = host_addr;
                        ram_wdata_d = host_wdata;
                        if (cpu_req && starve_q != STARVE_LIM) begin
                            starve_d = starve_q + SW'(1);
                        end
                    end else begin
                        ram_we_d    = 1'b0;
                        ram_addr_d  = cpu_addr;
                        ram_wdata_d = '0;
                        starve_d    = '0;
                    end
                end
            end
            ACCESS: begin
                state_d  = RESP;
                ram_en_d = 1'b0;
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d  = IDLE;
                ram_en_d = 1'b0;
            end
        endcase
    end

    // State registers; reset aborts any transaction in flight without an ack
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            ram_en_q    <= 1'b0;
            ram_we_q    <= 1'b0;
            ram_addr_q  <= '0;
            ram_wdata_q <= '0;
            win_host_q  <= 1'b0;
            last_host_q <= 1'b1;
            starve_q    <= '0;
        end else begin
            state_q     <= state_d;
            ram_en_q    <= ram_en_d;
            ram_we_q    <= ram_we_d;
            ram_addr_q  <= ram_addr_d;
            ram_wdata_q <= ram_wdata_d;
            win_host_q  <= win_host_d;
            last_host_q <= last_host_d;
            starve_q    <= starve_d;
        end
    end

    // Outputs: acks and read data come straight from RESP so the RAM's registered data lines up
    always_comb begin
        cpu_ack    = (state_q == RESP) && !win_host_q;
        host_ack   = (state_q == RESP) && win_host_q;
        cpu_rdata  = cpu_ack ? ram_rdata : '0;
        host_rdata = (host_ack && !ram_we_q) ? ram_rdata : '0;
        gnt_host   = win_host_q && (state_q != IDLE);
        ram_en     = ram_en_q;
        ram_we     = ram_we_q && ram_en_q;
        ram_addr   = ram_addr_q;
        ram_wdata  = ram_wdata_q;
    end

endmodule
